// File: rtl/pwm_meter_if.sv
// pwm_meter_if -- signal bundle between a PWM source/consumer and pwm_meter.
//   pwm_in      : asynchronous PWM waveform into the meter
//   period_cnt  : last complete period in clock cycles (rise to rise)
//   high_cnt    : high time of that period in clock cycles
//   duty        : min(255, floor(high_cnt*256/period_cnt))
//   valid       : one-cycle pulse when duty/period_cnt/high_cnt refresh
//   stuck       : line has shown no edge for TIMEOUT cycles
//   overrun     : sticky, a measurement was dropped while the divider was busy
// master = waveform source / result consumer, slave = the meter.
interface pwm_meter_if #(
   parameter int CNT_W = 32
) ();
   logic             pwm_in;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic [7:0]       duty;
   logic             valid;
   logic             stuck;
   logic             overrun;

   modport master (output pwm_in,
                   input  period_cnt, high_cnt, duty, valid, stuck, overrun);
   modport slave  (input  pwm_in,
                   output period_cnt, high_cnt, duty, valid, stuck, overrun);
endinterface

// File: rtl/pwm_meter.sv
// pwm_meter -- measures period and high time of an external PWM waveform and
// derives an 8-bit normalized duty with a 9-step serial restoring divider.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   mif  : pwm_meter_if slave (pwm_in in; period_cnt, high_cnt, duty, valid,
//          stuck, overrun out; all outputs registered)
module pwm_meter #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1000000
) (
   input logic       clk,
   input logic       rst,
   pwm_meter_if.slave mif
);
   localparam int               RW   = CNT_W + 9;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, pwm_s_q, pwm_d_q;
   logic [CNT_W-1:0] pc_q, pc_d;      // cycles since last rise
   logic [CNT_W-1:0] tc_q, tc_d;      // cycles since last edge of either kind
   logic [CNT_W-1:0] hl_q, hl_d;      // high time of the current period
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [7:0]       duty_q, duty_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;
   logic             ovr_q, ovr_d;
   logic             busy_q, busy_d;
   logic [3:0]       step_q, step_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [8:0]       quo_q, quo_d;
   logic [RW-1:0]    trial;
   logic             ge;
   logic             rise, fall;

   assign rise = pwm_s_q & ~pwm_d_q;
   assign fall = ~pwm_s_q & pwm_d_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = rise ? ONE : ((&pc_q) ? pc_q : pc_q + ONE);
      tc_d     = (rise | fall) ? ONE : ((&tc_q) ? tc_q : tc_q + ONE);
      hl_d     = fall ? pc_q : hl_q;
      period_d = period_q;
      high_d   = high_q;
      duty_d   = duty_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
      ovr_d    = ovr_q;
      busy_d   = busy_q;
      step_d   = step_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      trial    = '0;
      ge       = 1'b0;

      // Dividend is high*256: the first step compares high itself against the
      // divisor (quotient bit 8), each later step shifts in one zero bit.
      if (busy_q) begin
         trial  = (step_q == 4'd0) ? rem_q : {rem_q[RW-2:0], 1'b0};
         ge     = (trial >= {9'd0, period_q});
         rem_d  = ge ? (trial - {9'd0, period_q}) : trial;
         quo_d  = {quo_q[7:0], ge};
         step_d = step_q + 4'd1;
         if (step_q == 4'd8) begin
            busy_d  = 1'b0;
            duty_d  = quo_d[8] ? 8'hFF : quo_d[7:0];
            valid_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            // first partial period after reset is never reported
            if (rise) state_d = MEAS;
         end
         MEAS: begin
            if (rise) begin
               if (!busy_q) begin
                  period_d = pc_q;
                  high_d   = hl_q;
                  busy_d   = 1'b1;
                  step_d   = 4'd0;
                  rem_d    = {9'd0, hl_q};
                  quo_d    = '0;
               end else begin
                  ovr_d = 1'b1;
               end
            end else if (!fall && tc_q >= TO_C) begin
               // any edge in this cycle would have won over the timeout
               state_d  = STUCK;
               stuck_d  = 1'b1;
               duty_d   = pwm_s_q ? 8'hFF : 8'h00;
               period_d = '0;
               high_d   = '0;
               valid_d  = 1'b1;
               busy_d   = 1'b0;
            end
         end
         STUCK: begin
            if (rise) begin
               state_d = MEAS;
               stuck_d = 1'b0;
            end else if (fall) begin
               duty_d  = 8'h00;
               valid_d = 1'b1;
               pc_d    = ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b0;
         pwm_s_q  <= 1'b0;
         pwm_d_q  <= 1'b0;
         pc_q     <= '0;
         tc_q     <= '0;
         hl_q     <= '0;
         period_q <= '0;
         high_q   <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
         ovr_q    <= 1'b0;
         busy_q   <= 1'b0;
         step_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= mif.pwm_in;
         pwm_s_q  <= sync1_q;
         pwm_d_q  <= pwm_s_q;
         pc_q     <= pc_d;
         tc_q     <= tc_d;
         hl_q     <= hl_d;
         period_q <= period_d;
         high_q   <= high_d;
         duty_q   <= duty_d;
         valid_q  <= valid_d;
         stuck_q  <= stuck_d;
         ovr_q    <= ovr_d;
         busy_q   <= busy_d;
         step_q   <= step_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
      end
   end

   assign mif.period_cnt = period_q;
   assign mif.high_cnt   = high_q;
   assign mif.duty       = duty_q;
   assign mif.valid      = valid_q;
   assign mif.stuck      = stuck_q;
   assign mif.overrun    = ovr_q;
endmodule
